// File: rtl/hp0_axi_pkg.sv
// Shared HP0 AXI3 encodings and small elaboration-time helpers.
// Used by the HP0 burst writer and the HP0 read engine.
package hp0_axi_pkg;

    localparam int AXI3_ID_W  = 6;   // HP0 port ID width
    localparam int AXI3_LEN_W = 4;   // AXI3 burst length field
    localparam int AXI3_MAX_BURST = 16;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    // Bufferable + modifiable: lets the interconnect merge/split writes.
    localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    // AxSIZE encoding for a given bus width in bits.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    // Counter width able to hold 0..max_len inclusive.
    function automatic int burst_cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load 1.
// Ports: clk_i, reset_n_i (async active-low), clear_i, up_i, count_o.
module bsg_counter_clear_up #(
    parameter int max_val_p  = 16,
    parameter int init_val_p = 0,
    parameter int width_p    = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)   count_o <= width_p'(init_val_p);
        else if (clear_i) count_o <= width_p'(up_i);
        else if (up_i)    count_o <= count_o + width_p'(1);
    end

endmodule

// File: rtl/hp0_stream_burst_writer.sv
// Writes a valid/ready word stream to DRAM over HP0 as AXI3 INCR bursts,
// one burst outstanding at a time (AW, then W beats, then B).
// Ports: aclk/aresetn; CSR side start_i/base_addr_i/len_words_i and
// busy_o/done_o/error_o; stream side data_i/data_v_i/data_ready_o;
// HP0 AW/W/B master channels (AR/R belong to another block).
module hp0_stream_burst_writer
    import hp0_axi_pkg::*;
#(
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter int max_burst_len_p  = 16,
    parameter int len_width_p      = 24
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start_i,
    input  logic [axi_addr_width_p-1:0]   base_addr_i,
    input  logic [len_width_p-1:0]        len_words_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    input  logic [axi_data_width_p-1:0]   data_i,
    input  logic                          data_v_i,
    output logic                          data_ready_o,
    output logic [axi_addr_width_p-1:0]   hp0_axi_awaddr,
    output logic                          hp0_axi_awvalid,
    input  logic                          hp0_axi_awready,
    output logic [AXI3_ID_W-1:0]          hp0_axi_awid,
    output logic [1:0]                    hp0_axi_awlock,
    output logic [3:0]                    hp0_axi_awcache,
    output logic [2:0]                    hp0_axi_awprot,
    output logic [AXI3_LEN_W-1:0]         hp0_axi_awlen,
    output logic [2:0]                    hp0_axi_awsize,
    output logic [1:0]                    hp0_axi_awburst,
    output logic [3:0]                    hp0_axi_awqos,
    output logic [axi_data_width_p-1:0]   hp0_axi_wdata,
    output logic                          hp0_axi_wvalid,
    input  logic                          hp0_axi_wready,
    output logic [AXI3_ID_W-1:0]          hp0_axi_wid,
    output logic                          hp0_axi_wlast,
    output logic [axi_data_width_p/8-1:0] hp0_axi_wstrb,
    input  logic                          hp0_axi_bvalid,
    input  logic [AXI3_ID_W-1:0]          hp0_axi_bid,
    input  logic [1:0]                    hp0_axi_bresp,
    output logic                          hp0_axi_bready
);

    localparam int          CNT_W = burst_cnt_w(max_burst_len_p);
    localparam logic [2:0]  SIZE  = axi_size(axi_data_width_p);
    localparam logic [len_width_p-1:0] MAX_BEATS = len_width_p'(max_burst_len_p);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

    state_e                        state_q, state_d;
    logic [axi_addr_width_p-1:0]   addr_q;
    logic [len_width_p-1:0]        rem_q;
    logic [len_width_p-1:0]        beats;
    logic [CNT_W-1:0]              beat_cnt;
    logic                          error_q, done_q;
    logic                          last_beat, aw_fire, w_fire, b_fire, final_burst;

    // Only the final burst can be short; the base is burst-aligned, so no
    // burst ever straddles a 4KB page.
    assign beats       = (rem_q < MAX_BEATS) ? rem_q : MAX_BEATS;
    assign final_burst = (rem_q == beats);
    assign last_beat   = (beat_cnt == CNT_W'(beats - len_width_p'(1)));
    assign aw_fire     = (state_q == S_AW) && hp0_axi_awready;
    assign w_fire      = (state_q == S_W) && data_v_i && hp0_axi_wready;
    assign b_fire      = (state_q == S_B) && hp0_axi_bvalid;

    // Beats accepted in the current burst; restarts on each AW handshake.
    bsg_counter_clear_up #(
        .max_val_p  (max_burst_len_p),
        .init_val_p (0),
        .width_p    (CNT_W)
    ) u_beat_cnt (
        .clk_i     (aclk),
        .reset_n_i (aresetn),
        .clear_i   (aw_fire),
        .up_i      (w_fire),
        .count_o   (beat_cnt)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Valids/readies decode straight from state so an async reset drops
    // them in the same cycle.
    always_comb begin
        state_d         = state_q;
        hp0_axi_awvalid = 1'b0;
        hp0_axi_wvalid  = 1'b0;
        hp0_axi_wlast   = 1'b0;
        hp0_axi_bready  = 1'b0;
        data_ready_o    = 1'b0;
        case (state_q)
            S_IDLE: if (start_i && (len_words_i != '0)) state_d = S_AW;
            S_AW: begin
                hp0_axi_awvalid = 1'b1;
                if (hp0_axi_awready) state_d = S_W;
            end
            S_W: begin
                hp0_axi_wvalid = data_v_i;
                hp0_axi_wlast  = last_beat;
                data_ready_o   = hp0_axi_wready;
                if (w_fire && last_beat) state_d = S_B;
            end
            S_B: begin
                hp0_axi_bready = 1'b1;
                if (hp0_axi_bvalid) state_d = final_burst ? S_IDLE : S_AW;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q  <= '0;
            rem_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == S_IDLE) && start_i) begin
                addr_q  <= base_addr_i;
                rem_q   <= len_words_i;
                error_q <= 1'b0;
                done_q  <= (len_words_i == '0);
            end else if (b_fire) begin
                error_q <= error_q | (hp0_axi_bresp != AXI_RESP_OKAY);
                addr_q  <= addr_q + (axi_addr_width_p'(beats) << SIZE);
                rem_q   <= rem_q - beats;
                done_q  <= final_burst;
            end
        end
    end

    logic unused_bid;
    assign unused_bid = ^hp0_axi_bid;

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign hp0_axi_awaddr  = addr_q;
    assign hp0_axi_awlen   = AXI3_LEN_W'(beats - len_width_p'(1));
    assign hp0_axi_awid    = '0;
    assign hp0_axi_awlock  = '0;
    assign hp0_axi_awcache = AXI_CACHE_BUF_MOD;
    assign hp0_axi_awprot  = '0;
    assign hp0_axi_awsize  = SIZE;
    assign hp0_axi_awburst = AXI_BURST_INCR;
    assign hp0_axi_awqos   = '0;
    assign hp0_axi_wdata   = data_i;
    assign hp0_axi_wid     = '0;
    assign hp0_axi_wstrb   = '1;

endmodule
